// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small received-byte FIFO.
// Start edge is taken from the synchronised line; bits are sampled mid-period.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQUENCY = 10000000,
    parameter int unsigned BAUD_RATE     = 57600,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clki,
    input  logic                          reset,
    input  logic                          RX,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int unsigned BIT_PERIOD = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF       = BIT_PERIOD / 2;
    localparam int unsigned CW         = $clog2(BIT_PERIOD + 1);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BitPeriodC = CW'(BIT_PERIOD);
    localparam logic [CW-1:0] HalfC      = CW'(HALF);
    localparam logic [AW:0]   DepthC     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic          rx_s1_q, line_q, line_prev_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          overrun_q, overrun_d;
    logic          pop, full, accept, ovr_set;

    // Receive FSM: counter holds cycles since the last sample point.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (line_prev_q && !line_q) begin
                    state_d = StStart;
                    cnt_d   = CW'(1);
                end
            end
            StStart: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HalfC) begin
                    // A high line at mid-start is a glitch: drop back silently.
                    state_d = line_q ? StIdle : StData;
                    cnt_d   = line_q ? '0 : CW'(1);
                end
            end
            StData: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BitPeriodC) begin
                    cnt_d   = CW'(1);
                    shift_d = {line_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BitPeriodC) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    push        = line_q;
                    frame_err_d = !line_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO bookkeeping; rx_data is a registered copy of the head entry.
    always_comb begin
        pop      = rx_valid && rx_ready;
        full     = (count_q == DepthC);
        accept   = push && (!full || pop);
        ovr_set  = push && full && !pop;
        rd_next  = rd_ptr_q + AW'(1);
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop) count_d = count_q + (AW + 1)'(1);
        if (!accept && pop) count_d = count_q - (AW + 1)'(1);
        overrun_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
        rx_data_d = rx_data_q;
        if (count_q == '0) begin
            if (accept) rx_data_d = shift_q;
        end else if (pop) begin
            // With one entry left, the new head (if any) is the byte being pushed.
            if (count_q == (AW + 1)'(1)) begin
                if (accept) rx_data_d = shift_q;
            end else begin
                rx_data_d = mem_q[rd_next];
            end
        end
    end

    // State, synchroniser and FIFO control registers.
    always_ff @(posedge clki) begin
        if (reset) begin
            rx_s1_q     <= 1'b1;
            line_q      <= 1'b1;
            line_prev_q <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s1_q     <= RX;
            line_q      <= rx_s1_q;
            line_prev_q <= line_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage array; no reset needed since pointers define validity.
    always_ff @(posedge clki) begin
        if (!reset && accept) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = (count_q != '0);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign fill      = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames,
// every cycle compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BP    = 1600 / 100;
    localparam int unsigned HF    = BP / 2;
    // Two synchroniser cycles, then the stop-bit sample point.
    localparam int PUSH_CYC  = 2 + HF + 9 * BP;
    localparam int FRAME_LEN = 10 * BP + 4;

    logic       clki = 1'b0;
    logic       reset, RX, rx_ready, overrun_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [2:0] fill;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    logic [7:0] last_head = 8'h00;
    logic       ovr_m = 1'b0;
    logic       fe_m = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQUENCY(1600),
        .BAUD_RATE    (100),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clki       (clki),
        .reset      (reset),
        .RX         (RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .fill       (fill)
    );

    always #5 clki = ~clki;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, then advance the model.
    task automatic drive_cycle(input logic rxv, input logic rdy, input logic clr,
                               input logic rst, input logic ev, input logic stop_ok,
                               input logic [7:0] b);
        logic [7:0] exp_data;
        logic       set;
        RX          = rxv;
        rx_ready    = rdy;
        overrun_clr = clr;
        reset       = rst;
        @(negedge clki);
        exp_data = (q.size() != 0) ? q[0] : last_head;
        chk("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
        chk("fill", 32'(fill), 32'(q.size()));
        chk("rx_data", 32'(rx_data), 32'(exp_data));
        chk("frame_err", 32'(frame_err), 32'(fe_m));
        chk("overrun", 32'(overrun), 32'(ovr_m));
        last_head = exp_data;
        if (rst) begin
            q.delete();
            ovr_m     = 1'b0;
            fe_m      = 1'b0;
            last_head = 8'h00;
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            set = 1'b0;
            if (ev && stop_ok) begin
                if (q.size() < DEPTH) q.push_back(b);
                else set = 1'b1;
            end
            ovr_m = set ? 1'b1 : (clr ? 1'b0 : ovr_m);
            fe_m  = ev && !stop_ok;
        end
        @(posedge clki);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    // rdy_mode: 0 never ready, 1 random ready, 2 ready only in the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int rdy_mode,
                              input int clr_at, input int rst_at);
        logic aborted;
        logic rxv, rdy;
        int   bi;
        aborted = 1'b0;
        for (int c = 0; c < FRAME_LEN; c++) begin
            bi = c / BP;
            if (bi == 0) rxv = 1'b0;
            else if (bi <= 8) rxv = b[bi-1];
            else if (bi == 9) rxv = stop_ok;
            else rxv = 1'b1;
            case (rdy_mode)
                1:       rdy = ($urandom_range(0, 15) == 0);
                2:       rdy = (c == PUSH_CYC);
                default: rdy = 1'b0;
            endcase
            drive_cycle(rxv, rdy, c == clr_at, c == rst_at,
                        (c == PUSH_CYC) && !aborted, stop_ok, b);
            if (c == rst_at) aborted = 1'b1;
        end
    endtask

    initial begin
        RX = 1'b1; rx_ready = 1'b0; overrun_clr = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clki);
        #1;
        // Reset state, then a single byte held in the FIFO.
        idle(3, 1'b0);
        send_frame(8'hA5, 1'b1, 0, -1, -1);
        idle(3, 1'b0);
        idle(3, 1'b1);
        // Short low glitch on the line, then a frame right after it.
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(12, 1'b0);
        send_frame(8'h5A, 1'b1, 0, -1, -1);
        idle(2, 1'b1);
        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 0, -1, -1);
        send_frame(8'h11, 1'b1, 0, -1, -1);
        idle(2, 1'b1);
        // Overflow; clear collides with the set on the fifth byte.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, -1, -1);
        send_frame(8'h05, 1'b1, 0, PUSH_CYC, -1);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(6, 1'b1);
        // Full FIFO with a pop in the push cycle.
        for (int i = 1; i <= 4; i++) send_frame(8'h60 + 8'(i), 1'b1, 0, -1, -1);
        send_frame(8'h66, 1'b1, 2, -1, -1);
        idle(6, 1'b1);
        // Reset in the middle of a frame, with data already buffered.
        send_frame(8'h42, 1'b1, 0, -1, -1);
        send_frame(8'hFF, 1'b1, 0, -1, 2 + HF + 4 * BP - 4);
        send_frame(8'h7E, 1'b1, 0, -1, -1);
        idle(4, 1'b0);
        idle(4, 1'b1);
        // Random traffic.
        for (int k = 0; k < 14; k++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, 1, -1, -1);
            for (int g = 0; g < int'($urandom_range(1, 6)); g++)
                drive_cycle(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                            1'b0, 1'b0, 1'b1, 8'h00);
        end
        idle(6, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
